// File: rtl/conv_window_feeder_pkg.sv
// Shared constants, FSM state type and the OFM saturation helper for the convolve window feeder.
package conv_pkg;
  localparam int IMG_DIM = 28;
  localparam int K       = 5;
  localparam int PAD     = 2;
  localparam int N_CHN   = 3;
  localparam int PIX_W   = 3;
  localparam int RES_W   = 8;
  localparam int WIN_PIX = K*K;
  localparam int WIN_W   = WIN_PIX*PIX_W;
  localparam int IFM_AW  = 12;
  localparam int OFM_AW  = 10;
  localparam int ACC_W   = 10;
  localparam int CHN_W   = 2;
  localparam int CRD_W   = 5;
  localparam int SLOT_W  = 5;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_HS_HIGH, S_HS_LOW, S_WRITE, S_DONE
  } feeder_state_e;

  function automatic logic [RES_W-1:0] sat8(input logic [ACC_W-1:0] a);
    return (a > ACC_W'(255)) ? 8'hFF : a[RES_W-1:0];
  endfunction
endpackage

// File: rtl/conv_window_feeder_if.sv
// Frame control, IFM read port, convolve window handshake and OFM write port of the feeder.
interface conv_window_feeder_if;
  import conv_pkg::*;
  logic              start, busy, done;
  logic              ifm_re;
  logic [IFM_AW-1:0] ifm_addr;
  logic [PIX_W-1:0]  ifm_rdata;
  logic              valid_data;
  logic [WIN_W-1:0]  input_data;
  logic [CHN_W-1:0]  chn_sel;
  logic              ready;
  logic [RES_W-1:0]  result;
  logic              ofm_we;
  logic [OFM_AW-1:0] ofm_addr;
  logic [RES_W-1:0]  ofm_wdata;
  logic              timeout_err;

  modport master (
    input  start, ifm_rdata, ready, result,
    output busy, done, ifm_re, ifm_addr, valid_data, input_data, chn_sel,
           ofm_we, ofm_addr, ofm_wdata, timeout_err
  );
  modport slave (
    output start, ifm_rdata, ready, result,
    input  busy, done, ifm_re, ifm_addr, valid_data, input_data, chn_sel,
           ofm_we, ofm_addr, ofm_wdata, timeout_err
  );
endinterface

// File: rtl/conv_window_fetch.sv
// Gathers one zero-padded 5x5 window for (row,col,chn): 25 issue cycles plus one drain cycle.
module conv_window_fetch
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_fetch_i,
  input  logic [CRD_W-1:0]  row_i,
  input  logic [CRD_W-1:0]  col_i,
  input  logic [CHN_W-1:0]  chn_i,
  input  logic [PIX_W-1:0]  ifm_rdata_i,
  output logic              ifm_re_o,
  output logic [IFM_AW-1:0] ifm_addr_o,
  output logic              fetch_done_o,
  output logic [WIN_W-1:0]  window_o
);
  logic                           active_q, fill_q;
  logic [2:0]                     i_q, j_q;
  logic [SLOT_W-1:0]              slot_q, fill_slot_q;
  logic [WIN_PIX-1:0][PIX_W-1:0]  win_q;
  logic signed [CRD_W+1:0]        r_s, c_s;
  logic                           issue, in_rng;

  assign r_s    = $signed({2'b00, row_i}) + $signed({4'b0000, i_q}) - $signed(7'(PAD));
  assign c_s    = $signed({2'b00, col_i}) + $signed({4'b0000, j_q}) - $signed(7'(PAD));
  assign in_rng = (r_s >= 7'sd0) && (r_s < $signed(7'(IMG_DIM))) &&
                  (c_s >= 7'sd0) && (c_s < $signed(7'(IMG_DIM)));
  assign issue        = active_q && (slot_q < SLOT_W'(WIN_PIX));
  assign ifm_re_o     = issue && in_rng;
  assign fetch_done_o = active_q && (slot_q == SLOT_W'(WIN_PIX));
  assign ifm_addr_o   = ifm_re_o ? (IFM_AW'(chn_i) * IFM_AW'(IMG_DIM*IMG_DIM) +
                                    IFM_AW'(r_s[CRD_W-1:0]) * IFM_AW'(IMG_DIM) +
                                    IFM_AW'(c_s[CRD_W-1:0])) : '0;
  assign window_o     = win_q;

  // Slot k lives in element 24-k so that slot 0 lands in the window MSBs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q    <= 1'b0;
      fill_q      <= 1'b0;
      i_q         <= '0;
      j_q         <= '0;
      slot_q      <= '0;
      fill_slot_q <= '0;
      win_q       <= '0;
    end else begin
      fill_q      <= ifm_re_o;
      fill_slot_q <= slot_q;
      if (fill_q)
        win_q[SLOT_W'(WIN_PIX-1) - fill_slot_q] <= ifm_rdata_i;
      if (issue && !in_rng)
        win_q[SLOT_W'(WIN_PIX-1) - slot_q] <= '0;
      if (start_fetch_i) begin
        active_q <= 1'b1;
        slot_q   <= '0;
        i_q      <= '0;
        j_q      <= '0;
      end else if (active_q) begin
        if (fetch_done_o) begin
          active_q <= 1'b0;
        end else begin
          slot_q <= slot_q + SLOT_W'(1);
          if (j_q == 3'(K-1)) begin
            j_q <= '0;
            i_q <= i_q + 3'd1;
          end else begin
            j_q <= j_q + 3'd1;
          end
        end
      end
    end
  end
endmodule

// File: rtl/conv_window_feeder.sv
// Frame walker: fetches windows, runs the four-phase handshake with convolve, sums channels, writes OFM.
// Optional handshake watchdog enabled by defining CONV_FEEDER_TIMEOUT_EN.
module conv_window_feeder
  import conv_pkg::*;
`ifdef CONV_FEEDER_TIMEOUT_EN
#(
  parameter int TIMEOUT = 1024
)
`endif
(
  input logic            clk,
  input logic            rst_n,
  conv_window_feeder_if.master bus
);
  feeder_state_e    state_q, state_d;
  logic [CRD_W-1:0] row_q, row_d, col_q, col_d;
  logic [CHN_W-1:0] chn_q, chn_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             valid_q;
  logic             start_fetch, fetch_done, last_pix, timeout_hit;
  logic [WIN_W-1:0] window;

  conv_window_fetch u_fetch (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_fetch_i(start_fetch),
    .row_i        (row_q),
    .col_i        (col_q),
    .chn_i        (chn_q),
    .ifm_rdata_i  (bus.ifm_rdata),
    .ifm_re_o     (bus.ifm_re),
    .ifm_addr_o   (bus.ifm_addr),
    .fetch_done_o (fetch_done),
    .window_o     (window)
  );

  assign last_pix = (row_q == CRD_W'(IMG_DIM-1)) && (col_q == CRD_W'(IMG_DIM-1));

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    chn_d   = chn_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        state_d = S_FETCH;
        row_d   = '0;
        col_d   = '0;
        chn_d   = '0;
        acc_d   = '0;
      end
      S_FETCH: if (fetch_done) state_d = S_HS_HIGH;
      S_HS_HIGH: begin
        if (bus.ready) begin
          acc_d   = acc_q + ACC_W'(bus.result);
          state_d = S_HS_LOW;
        end else if (timeout_hit) begin
          state_d = S_DONE;
        end
      end
      S_HS_LOW: begin
        if (!bus.ready) begin
          if (chn_q != CHN_W'(N_CHN-1)) begin
            chn_d   = chn_q + CHN_W'(1);
            state_d = S_FETCH;
          end else begin
            state_d = S_WRITE;
          end
        end else if (timeout_hit) begin
          state_d = S_DONE;
        end
      end
      S_WRITE: begin
        chn_d = '0;
        acc_d = '0;
        if (last_pix) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FETCH;
          if (col_q == CRD_W'(IMG_DIM-1)) begin
            col_d = '0;
            row_d = row_q + CRD_W'(1);
          end else begin
            col_d = col_q + CRD_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign start_fetch = (state_d == S_FETCH) && (state_q != S_FETCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      chn_q   <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      chn_q   <= chn_d;
      acc_q   <= acc_d;
      valid_q <= (state_d == S_HS_HIGH);
    end
  end

`ifdef CONV_FEEDER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT+1);
  logic [TO_W-1:0] to_cnt_q;
  logic            to_err_q;
  logic            in_hs;

  assign in_hs       = (state_q == S_HS_HIGH) || (state_q == S_HS_LOW);
  assign timeout_hit = in_hs && (to_cnt_q == TO_W'(TIMEOUT-1));

  // Counter restarts on every phase change so each phase gets its own budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      if (state_d != state_q) to_cnt_q <= '0;
      else if (in_hs)         to_cnt_q <= to_cnt_q + TO_W'(1);
      if (in_hs && state_d == S_DONE) to_err_q <= 1'b1;
    end
  end
  assign bus.timeout_err = to_err_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.valid_data = valid_q;
  assign bus.input_data = window;
  assign bus.chn_sel    = chn_q;
  assign bus.ofm_we     = (state_q == S_WRITE);
  assign bus.ofm_addr   = OFM_AW'(row_q) * OFM_AW'(IMG_DIM) + OFM_AW'(col_q);
  assign bus.ofm_wdata  = sat8(acc_q);
endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: IFM RAM model, convolve responder, OFM scoreboard against a window-sum model.
module tb_conv_window_feeder;
  import conv_pkg::*;

  localparam int NPIX = IMG_DIM*IMG_DIM;
  localparam int NIFM = N_CHN*NPIX;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_window_feeder_if bus();
  conv_window_feeder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0, passes = 0;
  logic [PIX_W-1:0] ifm [NIFM];
  int wt[N_CHN], salt[N_CHN];
  int exp_ofm[NPIX], ofm_mem[NPIX];
  int wr_cnt, done_cnt, hs_cnt, re_cnt, early_err, addr_err;
  bit slow;
  logic [WIN_W-1:0] first_win;
  int first_re, first_chn;
  bit rd_pend;
  logic [PIX_W-1:0] rd_val;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic bit inr(int r, int c);
    return r >= 0 && r < IMG_DIM && c >= 0 && c < IMG_DIM;
  endfunction

  function automatic int win_sum(int ch, int r, int c);
    int s = 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        if (inr(r+i-PAD, c+j-PAD)) s += int'(ifm[ch*NPIX + (r+i-PAD)*IMG_DIM + (c+j-PAD)]);
    return s;
  endfunction

  function automatic logic [WIN_W-1:0] win_of(int ch, int r, int c, bit mask_only);
    logic [WIN_W-1:0] w = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) begin
        if (mask_only) begin
          if (!inr(r+i-PAD, c+j-PAD)) w[WIN_W-1-(i*K+j)*PIX_W -: PIX_W] = '1;
        end else if (inr(r+i-PAD, c+j-PAD)) begin
          w[WIN_W-1-(i*K+j)*PIX_W -: PIX_W] = ifm[ch*NPIX + (r+i-PAD)*IMG_DIM + (c+j-PAD)];
        end
      end
    return w;
  endfunction

  function automatic int resp(int s, int ch);
    return (s*wt[ch] + salt[ch]) % 256;
  endfunction

  task automatic build_expect();
    for (int p = 0; p < NPIX; p++) begin
      int tot = 0;
      for (int ch = 0; ch < N_CHN; ch++) tot += resp(win_sum(ch, p/IMG_DIM, p%IMG_DIM), ch);
      exp_ofm[p] = (tot > 255) ? 255 : tot;
    end
  endtask

  // IFM RAM: data for a read issued in cycle t is presented during cycle t+1, garbage otherwise.
  initial begin
    rd_pend = 0; rd_val = '0; bus.ifm_rdata = '0;
    forever begin
      @(negedge clk);
      bus.ifm_rdata = rd_pend ? rd_val : PIX_W'($urandom);
      rd_pend = bus.ifm_re;
      if (bus.ifm_re) begin
        re_cnt++;
        if (bus.ifm_addr < IFM_AW'(NIFM)) rd_val = ifm[bus.ifm_addr];
        else begin rd_val = '0; addr_err++; end
      end
    end
  end

  // Convolve responder: result = weighted window sum, with configurable ready delay and hold.
  initial begin
    int ph = 0, cnt = 0, hold = 1, s;
    logic [RES_W-1:0] rres = '0;
    bus.ready = 0; bus.result = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.ready = 0; ph = 0;
      end else case (ph)
        0: if (bus.valid_data) begin
          s = 0;
          for (int k = 0; k < WIN_PIX; k++) s += int'(bus.input_data[WIN_W-1-k*PIX_W -: PIX_W]);
          rres = RES_W'(resp(s, int'(bus.chn_sel)));
          if (hs_cnt == 0) begin first_win = bus.input_data; first_re = re_cnt; first_chn = int'(bus.chn_sel); end
          hs_cnt++;
          case ($urandom_range(0, 2)) 0: cnt = 0; 1: cnt = 1; default: cnt = 7; endcase
          if (!slow) cnt = 0;
          hold = (slow && $urandom_range(0, 1) == 1) ? 5 : 1;
          if (cnt == 0) begin bus.ready = 1; bus.result = rres; cnt = hold; ph = 2; end
          else ph = 1;
        end
        1: begin
          cnt--;
          if (cnt == 0) begin bus.ready = 1; bus.result = rres; cnt = hold; ph = 2; end
        end
        default: begin
          if (bus.valid_data) early_err++;
          cnt--;
          if (cnt == 0) begin bus.ready = 0; bus.result = RES_W'($urandom); ph = 0; end
        end
      endcase
    end
  end

  // OFM scoreboard: writes must come in raster order with the modelled values.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.ofm_we) begin
        chk("ofm_order", 80'(bus.ofm_addr), 80'(wr_cnt));
        if (bus.ofm_addr < OFM_AW'(NPIX)) begin
          chk("ofm_data", 80'(bus.ofm_wdata), 80'(exp_ofm[bus.ofm_addr]));
          ofm_mem[bus.ofm_addr] = int'(bus.ofm_wdata);
        end
        wr_cnt++;
      end
      if (bus.done) begin
        done_cnt++;
        chk("busy_at_done", 80'(bus.busy), 80'd0);
      end
    end
  end

  typedef struct { int r; int c; int exp; } spot_t;
  spot_t tbl[10];

  initial begin
    int n;
    tbl[0] = '{0, 0, 108};  tbl[1] = '{0, 1, 144};   tbl[2] = '{1, 1, 192};
    tbl[3] = '{0, 2, 180};  tbl[4] = '{1, 2, 240};   tbl[5] = '{2, 2, 255};
    tbl[6] = '{14, 14, 255}; tbl[7] = '{27, 27, 108}; tbl[8] = '{13, 27, 180};
    tbl[9] = '{27, 0, 108};
    wr_cnt = 0; done_cnt = 0; hs_cnt = 0; re_cnt = 0; early_err = 0; addr_err = 0;
    first_win = '0; first_re = 0; first_chn = 0; slow = 0;
    for (int p = 0; p < NIFM; p++) ifm[p] = '0;
    for (int ch = 0; ch < N_CHN; ch++) begin wt[ch] = 1; salt[ch] = 0; end
    rst_n = 0; bus.start = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 80'(bus.busy), 80'd0);
    chk("rst_done", 80'(bus.done), 80'd0);
    chk("rst_ifm_re", 80'(bus.ifm_re), 80'd0);
    chk("rst_valid", 80'(bus.valid_data), 80'd0);
    chk("rst_ofm_we", 80'(bus.ofm_we), 80'd0);
    chk("rst_timeout", 80'(bus.timeout_err), 80'd0);
    chk("rst_window", 80'(bus.input_data), 80'd0);
    chk("rst_chn", 80'(bus.chn_sel), 80'd0);
    chk("rst_ifm_addr", 80'(bus.ifm_addr), 80'd0);
    chk("rst_ofm_addr", 80'(bus.ofm_addr), 80'd0);
    rst_n = 1;
    @(negedge clk);

    // Random IFM and responder weights, slow/irregular handshakes for the first pixels.
    for (int p = 0; p < NIFM; p++) ifm[p] = PIX_W'($urandom_range(0, 7));
    for (int ch = 0; ch < N_CHN; ch++) begin wt[ch] = $urandom_range(1, 3); salt[ch] = $urandom_range(0, 255); end
    build_expect();
    slow = 1;
    bus.start = 1; @(negedge clk); bus.start = 0;
    chk("busy_after_start", 80'(bus.busy), 80'd1);
    n = 0; while (hs_cnt < 1 && n < 200) begin @(negedge clk); n++; end
    chk("first_hs_seen", 80'(hs_cnt >= 1), 80'd1);
    chk("corner_re_pulses", 80'(first_re), 80'd9);
    chk("corner_chn", 80'(first_chn), 80'd0);
    chk("corner_window", 80'(first_win), 80'(win_of(0, 0, 0, 0)));
    chk("corner_pad_zero", 80'(first_win & win_of(0, 0, 0, 1)), 80'd0);
    n = 0; while (wr_cnt < 20 && n < 8000) begin @(negedge clk); n++; end
    chk("slow_pixels_written", 80'(wr_cnt >= 20), 80'd1);
    slow = 0;

    // Abort at pixel (3,5), channel 1, while the window is being offered.
    n = 0;
    while (!(wr_cnt == 3*IMG_DIM+5 && bus.chn_sel == 2'd1 && bus.valid_data) && n < 20000) begin
      @(negedge clk); n++;
    end
    chk("abort_point_reached", 80'(n < 20000), 80'd1);
    rst_n = 0;
    #1;
    chk("abort_busy", 80'(bus.busy), 80'd0);
    chk("abort_valid", 80'(bus.valid_data), 80'd0);
    chk("abort_chn", 80'(bus.chn_sel), 80'd0);
    chk("abort_window", 80'(bus.input_data), 80'd0);
    chk("abort_ofm_we", 80'(bus.ofm_we), 80'd0);
    repeat (3) @(negedge clk);
    chk("abort_no_write", 80'(wr_cnt), 80'(3*IMG_DIM+5));
    rst_n = 1;
    @(negedge clk);

    // Full frame: IFM all ones, channel weights 3/4/5, fast handshakes.
    for (int p = 0; p < NIFM; p++) ifm[p] = 3'd1;
    for (int ch = 0; ch < N_CHN; ch++) begin wt[ch] = 3 + ch; salt[ch] = 0; end
    for (int p = 0; p < NPIX; p++) ofm_mem[p] = -1;
    build_expect();
    wr_cnt = 0; done_cnt = 0; hs_cnt = 0; re_cnt = 0; early_err = 0;
    bus.start = 1; @(negedge clk); bus.start = 0;
    repeat (500) @(negedge clk);
    bus.start = 1; @(negedge clk); bus.start = 0;
    n = 0; while (done_cnt < 1 && n < 80000) begin @(negedge clk); n++; end
    chk("frame_done", 80'(done_cnt >= 1), 80'd1);
    repeat (5) @(negedge clk);
    chk("frame_writes", 80'(wr_cnt), 80'(NPIX));
    chk("frame_done_pulses", 80'(done_cnt), 80'd1);
    chk("frame_handshakes", 80'(hs_cnt), 80'(NPIX*N_CHN));
    chk("frame_ifm_reads", 80'(re_cnt), 80'd53868);
    chk("no_early_valid", 80'(early_err), 80'd0);
    chk("ifm_addr_range", 80'(addr_err), 80'd0);
    chk("idle_busy", 80'(bus.busy), 80'd0);
    chk("idle_timeout", 80'(bus.timeout_err), 80'd0);
    for (int t = 0; t < 10; t++)
      chk($sformatf("spot_%0d_%0d", tbl[t].r, tbl[t].c),
          80'(ofm_mem[tbl[t].r*IMG_DIM + tbl[t].c]), 80'(tbl[t].exp));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
